// File: rtl/gate_drv_pkg.sv
// gate_drv_pkg: shared types and constants for the half-bridge gate driver.
//   state_t   : FSM state encoding (6 states, 3 bits)
//   DT_MIN    : shortest dead period in clk cycles (dead_time of 0 maps here)
//   DT_W_DEF  : default dead-time counter width
//   WD_W_DEF  : default edge-watchdog counter width
package gate_drv_pkg;

  localparam int DT_W_DEF = 8;
  localparam int WD_W_DEF = 12;
  localparam int DT_MIN   = 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DEAD_H = 3'd1,
    ST_HI     = 3'd2,
    ST_DEAD_L = 3'd3,
    ST_LO     = 3'd4,
    ST_FAULT  = 3'd5
  } state_t;

endpackage

// File: rtl/gate_drv_sync2.sv
// sync2: generic two-flop synchronizer for a single asynchronous level.
//   clk   in  : destination clock
//   reset in  : asynchronous, active-low; both flops clear to 0
//   d     in  : asynchronous input
//   q     out : d resynchronized to clk (two-cycle latency)
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/gate_drv.sv
// gate_drv: complementary half-bridge gate-drive generator.
// Turns the oscillator square wave into non-overlapping high/low gate
// commands separated by a programmable dead time, gated by an interrupter
// enable, with an edge watchdog and a latched overcurrent fault.
//   clk       in  : core clock (oscillator domain)
//   reset     in  : asynchronous, active-low
//   osc_in    in  : oscillator square wave, synchronous to clk
//   enable    in  : interrupter gate level
//   dead_time in  : dead period in cycles, 0 behaves as 1
//   fault_in  in  : overcurrent comparator, asynchronous
//   fault_clr in  : one-cycle pulse clearing a latched fault
//   gate_hi   out : high-side gate command
//   gate_lo   out : low-side gate command
//   active    out : bridge running (not IDLE, not FAULT)
//   fault     out : fault latched
//   stall     out : one-cycle pulse on watchdog timeout
module gate_drv
  import gate_drv_pkg::*;
#(
  parameter int DT_W = DT_W_DEF,
  parameter int WD_W = WD_W_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            osc_in,
  input  logic            enable,
  input  logic [DT_W-1:0] dead_time,
  input  logic            fault_in,
  input  logic            fault_clr,
  output logic            gate_hi,
  output logic            gate_lo,
  output logic            active,
  output logic            fault,
  output logic            stall
);

  localparam logic [WD_W-1:0] WD_MAX  = '1;
  // One below saturation: expiring here lets stall land on the cycle the
  // counter reaches its ceiling.
  localparam logic [WD_W-1:0] WD_LAST = {{(WD_W-1){1'b1}}, 1'b0};

  function automatic logic [DT_W-1:0] dt_load(input logic [DT_W-1:0] d);
    return (d < DT_W'(DT_MIN)) ? DT_W'(DT_MIN) : d;
  endfunction

  state_t          state, state_nxt;
  logic [DT_W-1:0] dt_cnt, dt_nxt;
  logic [WD_W-1:0] wd_cnt, wd_nxt;
  logic            stall_nxt;
  logic            osc_q, fault_s;
  logic            rise, fall, osc_edge, run_nxt;

  sync2 u_fault_sync (
    .clk   (clk),
    .reset (reset),
    .d     (fault_in),
    .q     (fault_s)
  );

  assign rise     = osc_in & ~osc_q;
  assign fall     = ~osc_in & osc_q;
  assign osc_edge = rise | fall;

  always_comb begin
    state_nxt = state;
    dt_nxt    = dt_cnt;
    wd_nxt    = wd_cnt;
    stall_nxt = 1'b0;
    if (fault_s) begin
      state_nxt = ST_FAULT;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rise && enable) begin
            state_nxt = ST_DEAD_H;
            dt_nxt    = dt_load(dead_time);
          end
        end
        ST_DEAD_H: begin
          if (fall) begin
            state_nxt = enable ? ST_DEAD_L : ST_IDLE;
            dt_nxt    = dt_load(dead_time);
          end else begin
            if (dt_cnt == DT_W'(DT_MIN)) state_nxt = ST_HI;
            dt_nxt = dt_cnt - DT_W'(1);
          end
        end
        ST_DEAD_L: begin
          if (rise) begin
            state_nxt = enable ? ST_DEAD_H : ST_IDLE;
            dt_nxt    = dt_load(dead_time);
          end else begin
            if (dt_cnt == DT_W'(DT_MIN)) state_nxt = ST_LO;
            dt_nxt = dt_cnt - DT_W'(1);
          end
        end
        ST_HI: begin
          if (fall) begin
            state_nxt = enable ? ST_DEAD_L : ST_IDLE;
            dt_nxt    = dt_load(dead_time);
          end else if (wd_cnt == WD_LAST) begin
            state_nxt = ST_IDLE;
            stall_nxt = 1'b1;
          end
        end
        ST_LO: begin
          if (rise) begin
            state_nxt = enable ? ST_DEAD_H : ST_IDLE;
            dt_nxt    = dt_load(dead_time);
          end else if (wd_cnt == WD_LAST) begin
            state_nxt = ST_IDLE;
            stall_nxt = 1'b1;
          end
        end
        ST_FAULT: begin
          if (fault_clr) state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end

    // Watchdog restarts on every oscillator edge and on each gate-on entry.
    if (osc_edge ||
        ((state_nxt == ST_HI || state_nxt == ST_LO) && state_nxt != state)) begin
      wd_nxt = '0;
    end else if ((state == ST_HI || state == ST_LO) && wd_cnt != WD_MAX) begin
      wd_nxt = wd_cnt + WD_W'(1);
    end

    run_nxt = (state_nxt != ST_IDLE) && (state_nxt != ST_FAULT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      osc_q   <= 1'b0;
      dt_cnt  <= '0;
      wd_cnt  <= '0;
      gate_hi <= 1'b0;
      gate_lo <= 1'b0;
      active  <= 1'b0;
      fault   <= 1'b0;
      stall   <= 1'b0;
    end else begin
      state   <= state_nxt;
      osc_q   <= osc_in;
      dt_cnt  <= dt_nxt;
      wd_cnt  <= wd_nxt;
      gate_hi <= (state_nxt == ST_HI);
      gate_lo <= (state_nxt == ST_LO);
      active  <= run_nxt;
      fault   <= (state_nxt == ST_FAULT);
      stall   <= stall_nxt;
    end
  end

endmodule

// File: doc/gate_drv.md
# gate_drv

Complementary half-bridge gate-drive generator sitting directly downstream of the `pll` oscillator output. Converts the single-ended `osc_out` square wave into non-overlapping high-side and low-side gate commands with programmable dead time. Gates the bridge with an interrupter enable that only starts and stops on oscillator edges. Latches an overcurrent fault that forces both gates off until explicitly cleared.

## Interface
- `DT_W`, 8: dead-time counter width, in clk cycles.
- `WD_W`, 12: edge-watchdog counter width.
- `clk` in 1: core clock, the same domain as the `pll`.
- `reset` in 1: reset, asynchronous, active-low; clock clk.
- `osc_in` in 1: oscillator from the `pll` `osc_out`; already synchronous to `clk`.
- `enable` in 1: interrupter gate, synchronous level.
- `dead_time` in DT_W: dead time in cycles; 0 is treated as 1.
- `fault_in` in 1: overcurrent comparator; asynchronous.
- `fault_clr` in 1: single-cycle pulse that clears the latched fault.
- `gate_hi` out 1: high-side gate command.
- `gate_lo` out 1: low-side gate command.
- `active` out 1: bridge running (state not IDLE or FAULT).
- `fault` out 1: fault latched.
- `stall` out 1: one-cycle pulse on watchdog timeout.

## Operation
- **States:** IDLE, DEAD_H, HI, DEAD_L, LO, FAULT. All outputs are registered and decoded from the state.
- **Edge detection:**
  - `osc_q` holds `osc_in` delayed by one cycle.
  - Rise = `osc_in & !osc_q`; fall = `!osc_in & osc_q`.
  - `osc_q` resets to 0.
- **IDLE:** on a rise with `enable`=1 → DEAD_H. All other inputs are ignored. A fall never starts the bridge.
- **DEAD_H / DEAD_L:**
  - Both gates low.
  - `dt_cnt` is loaded with max(`dead_time`,1) on entry and decrements each cycle.
  - When `dt_cnt`==1, go to HI (respectively LO).
- **HI:** `gate_hi`=1. On a fall: with `enable`=1 → DEAD_L; with `enable`=0 → IDLE.
- **LO:** `gate_lo`=1. On a rise: with `enable`=1 → DEAD_H; with `enable`=0 → IDLE.
- **Edge arriving during a dead state:**
  - Opposite edge → move to the opposite dead state and reload `dt_cnt` (or IDLE if `enable`=0).
  - Same-direction edge is impossible by construction.
- **Watchdog:**
  - `wd_cnt` clears on any edge and on entry to HI or LO.
  - It increments in HI and LO and saturates at 2^WD_W−1.
  - On reaching 2^WD_W−1 → IDLE, and `stall` pulses for 1 cycle.
- **Fault path:**
  - `fault_in` passes through a 2-flop synchronizer.
  - A synchronized high in any state → FAULT, both gates low, `fault`=1. Fault has priority over every other transition.
  - FAULT → IDLE only when `fault_clr`=1 and the synchronized fault is 0. A clear is ignored while the fault is still asserted.
- **Invariant:** `gate_hi & gate_lo` is never 1. Every gate transition passes through at least 1 cycle with both low.
- `dead_time` is sampled only at the `dt_cnt` load; mid-count changes take effect at the next dead period.

## Timing
- **Reset:** all outputs 0, state IDLE, `osc_q`=0, counters 0, synchronizer flops 0.
- **Deassertion:** `reset` deassertion is synchronous to the `clk` edge by the upstream reset counter; the first active cycle after it behaves as IDLE.
- **Dead time:** an edge seen at cycle n puts both gates low at n+1. The new gate rises at n+1+D, where D = max(`dead_time`,1).
- **Enable off:** a stopping edge at n gives gates low at n+1 and `active`=0 at n+1.
- **Fault:** `fault_in` rising before the clk edge at n gives gates low and `fault`=1 at n+3 at the latest.
- **Fault clear:** `fault_clr` at n (with fault clear) gives `fault`=0 and IDLE at n+1. Restart needs a later rise.
- **Simultaneous events:**
  - Fault plus edge in the same cycle → FAULT.
  - Watchdog expiry plus edge in the same cycle → the edge wins and `stall` does not pulse.
- **Reset mid-operation:** gates are low immediately (asynchronous) and all state is discarded.

## Structure
- `gate_drv_pkg` holds:
  - the state enum (6 states, 3-bit encoding);
  - the `DT_MIN`=1 constant;
  - the default widths for `DT_W` and `WD_W`.
- Sub-module `sync2`: the generic 2-flop synchronizer with asynchronous active-low reset, used for `fault_in`. It is reusable for the `pmod00` feedback input.
- `gate_drv` contains the FSM, `dt_cnt`, `wd_cnt` and the output registers.

## Test plan
- **Dead time = 4, enable=1, `osc_in` period 40 cycles (50% duty):** first rise at cycle 0 gives `gate_hi`=1 at 5. The fall at 20 gives `gate_hi`=0 at 21 and `gate_lo`=1 at 25. Overlap is never seen.
- **`dead_time`=0:** exactly 1 dead cycle per transition. With `dead_time`=30 and a half-period of 20, gates stay low continuously while `active`=1.
- **Enable drops mid-burst at cycle 100 (gate high):** `gate_hi` stays 1 until the next fall, then both gates are 0 the following cycle and `active`=0. A fall with enable=1 in IDLE does not restart the bridge; the next rise with enable=1 does.
- **Pulse `fault_in` high for 1 cycle while in HI:** gates are 0 and `fault`=1 within 3 cycles and stay latched over 10 further edges. `fault_clr` while `fault_in` is held high is ignored. `fault_clr` after release returns to IDLE.
- **`osc_in` held high for 5000 cycles with WD_W=12:** `stall` pulses once at 4095 cycles after HI entry, then the block is in IDLE with both gates 0.
- **`reset` asserted during LO:** `gate_lo`=0 immediately. After release the block waits in IDLE for a rise.
